controlador_memoria_ula: RTL and testbench
==========================================

# controlador_memoria_ula

Sequencing controller that sits between the operand and opcode inputs, the combinational ULA, and the 8-bit memory register. It accepts one operation request at a time and presents registered operands to the ULA. After a fixed latency it captures the result and issues a single load pulse that writes the result, or zero on a clear request, into the memory register. It also supports memory recall, where the stored value replaces operand A, and error-protected write suppression.

## Interface
Parameters:
- LARGURA, 8: datapath width of operands, result and memory value.
- LATENCIA_ULA, 1: cycles the ULA result needs before capture (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- iniciar  input  1  operation request; sampled only when ocupado=0.
- limpar_memoria  input  1  memory clear request; sampled only when ocupado=0.
- usar_memoria  input  1  qualifier of iniciar: operand A := valor_memoria.
- operando_a, operando_b  input  LARGURA  user operands.
- opcode  input  3  ULA operation code (ula_pkg encoding).
- valor_memoria  input  LARGURA  current memory register output.
- resultado_ula  input  LARGURA  ULA result.
- erro_ula  input  1  ULA error flag (overflow / divide by zero).
- ula_a, ula_b  output  LARGURA  registered ULA operands.
- ula_op  output  3  registered ULA opcode.
- carregar  output  1  one-cycle load pulse to the memory register.
- resultado_entrada  output  LARGURA  value to be loaded.
- ocupado  output  1  controller busy; new requests are ignored.
- concluido  output  1  one-cycle completion pulse.
- erro  output  1  error status of the last completed operation.

## Operation
- States: OCIOSO, EXECUTA, GRAVA, LIMPA.
- OCIOSO with limpar_memoria=1 goes to LIMPA. Clear has priority over iniciar; a simultaneous iniciar is dropped and not queued.
- OCIOSO with iniciar=1 (and limpar_memoria=0) goes to EXECUTA:
  - ula_a := usar_memoria ? valor_memoria : operando_a.
  - ula_b := operando_b; ula_op := opcode.
  - Counter := LATENCIA_ULA-1; erro := 0.
- EXECUTA: decrement the counter. At 0, capture resultado_ula into resultado_entrada and erro_ula into erro, then go to GRAVA.
- GRAVA: carregar = !erro (see Configuration); concluido=1. Next state OCIOSO.
- LIMPA: resultado_entrada=0, carregar=1, concluido=1, erro := 0. Next state OCIOSO.
- ocupado=1 in every state except OCIOSO. Inputs other than valor_memoria, resultado_ula and erro_ula are ignored while busy.
- ula_a, ula_b and ula_op hold their values after completion until the next accepted iniciar.
- Arithmetic is entirely inside the ULA. The controller does no width conversion; all buses are LARGURA bits.

## Timing
- Reset (rst=1 at an edge): state OCIOSO, all outputs 0, counter 0.
- A reset in any state aborts the operation with no carregar pulse.
- iniciar accepted at edge E0 → EXECUTA during cycles 1..LATENCIA_ULA → GRAVA in cycle LATENCIA_ULA+1, where carregar and concluido are high.
- The memory register holds the new value after edge E(LATENCIA_ULA+2).
- Clear: accepted at E0; LIMPA in cycle 1 with carregar=1; memory is zero after E2.
- Back-to-back: a new request can be accepted in the first OCIOSO cycle after GRAVA or LIMPA. Maximum throughput is one operation per LATENCIA_ULA+2 cycles.
- carregar and concluido are never high for more than one consecutive cycle.
- erro is a level; it is valid from the GRAVA cycle until the next accepted request or reset.

## Configuration
- CONTROLADOR_PROTEGE_ERRO_EN defined:
  - erro follows the captured erro_ula.
  - GRAVA suppresses carregar when erro=1, so memory keeps its old value.
  - concluido still pulses.
- Not defined:
  - erro_ula is ignored and erro stays 0.
  - GRAVA always asserts carregar.

## Structure
- Package ula_pkg holds:
  - Opcode constants (000 soma, 001 subtracao, 010 and, 011 or, 100 xor, 101 mult, 110 div, 111 passa_a).
  - Default LARGURA.
  - State encoding of controlador_memoria_ula (2 bits).
- One sub-module, contador_latencia: a loadable down-counter with a zero flag, used by EXECUTA.
- All other logic lives in this module.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, ocupado=0.
- With LATENCIA_ULA=1: iniciar, opcode=000, a=8'h12, b=8'h05; ULA model returns 8'h17 → ula_a=12, ula_b=05 in cycle 1; carregar=1 and resultado_entrada=17 in cycle 2; memory=17 afterwards.
- Memory=8'h17; iniciar with usar_memoria=1, opcode=001, operando_a=8'hFF, b=8'h07 → ula_a=17 (operando_a not used); stored result 8'h10.
- With the macro defined: div, b=0, erro_ula=1 → concluido pulses, carregar stays 0, erro=1, memory unchanged. Without the macro → carregar=1 and erro=0.
- iniciar and limpar_memoria high in the same cycle with memory=8'h17 → LIMPA; resultado_entrada=0, carregar=1; memory=0; no ULA operands loaded.
- Extra requests:
  - With LATENCIA_ULA=3, pulse iniciar during EXECUTA → ignored; exactly one concluido pulse, in cycle 4.
  - rst during EXECUTA → no carregar pulse; state OCIOSO the next cycle.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ULA datapath and its memory controller.
// Holds the ULA opcode encoding, the default datapath width and the state
// encoding used by controlador_memoria_ula.
package ula_pkg;

   localparam int unsigned LARGURA_PADRAO = 8;

   // ULA opcode encoding
   localparam logic [2:0] OP_SOMA      = 3'b000;
   localparam logic [2:0] OP_SUBTRACAO = 3'b001;
   localparam logic [2:0] OP_AND       = 3'b010;
   localparam logic [2:0] OP_OR        = 3'b011;
   localparam logic [2:0] OP_XOR       = 3'b100;
   localparam logic [2:0] OP_MULT      = 3'b101;
   localparam logic [2:0] OP_DIV       = 3'b110;
   localparam logic [2:0] OP_PASSA_A   = 3'b111;

   // controlador_memoria_ula states
   typedef enum logic [1:0] {
      OCIOSO  = 2'b00,
      EXECUTA = 2'b01,
      GRAVA   = 2'b10,
      LIMPA   = 2'b11
   } estado_t;

endpackage

// File: rtl/contador_latencia.sv
// contador_latencia: loadable down-counter with a zero flag.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   carga        load valor into the counter (has priority over decrementar)
//   valor        load value
//   decrementar  count down by one; the counter saturates at zero
//   zero         high while the count is zero
module contador_latencia #(
   parameter int unsigned LARGURA_CONT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    carga,
   input  logic [LARGURA_CONT-1:0] valor,
   input  logic                    decrementar,
   output logic                    zero
);

   logic [LARGURA_CONT-1:0] contagem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         contagem_q <= '0;
      end else if (carga) begin
         contagem_q <= valor;
      end else if (decrementar && (contagem_q != '0)) begin
         contagem_q <= contagem_q - 1'b1;
      end
   end

   assign zero = (contagem_q == '0);

endmodule

// File: rtl/controlador_memoria_ula.sv
// controlador_memoria_ula: sequences one ULA operation at a time and writes
// the result (or zero on a clear request) into the memory register.
// Optional feature macro: CONTROLADOR_PROTEGE_ERRO_EN -- when defined, the
// captured erro_ula is reported on erro and suppresses the memory write.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   iniciar, limpar_memoria  operation / clear requests (sampled when idle)
//   usar_memoria             operand A comes from valor_memoria
//   operando_a, operando_b   user operands; opcode: ULA operation
//   valor_memoria            memory register output
//   resultado_ula, erro_ula  ULA result and error flag
//   ula_a, ula_b, ula_op     registered ULA operands and opcode
//   carregar                 one-cycle load pulse to the memory register
//   resultado_entrada        value to be loaded
//   ocupado, concluido, erro busy level, completion pulse, error status
module controlador_memoria_ula
   import ula_pkg::*;
#(
   parameter int unsigned LARGURA      = LARGURA_PADRAO,
   parameter int unsigned LATENCIA_ULA = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               iniciar,
   input  logic               limpar_memoria,
   input  logic               usar_memoria,
   input  logic [LARGURA-1:0] operando_a,
   input  logic [LARGURA-1:0] operando_b,
   input  logic [2:0]         opcode,
   input  logic [LARGURA-1:0] valor_memoria,
   input  logic [LARGURA-1:0] resultado_ula,
   input  logic               erro_ula,
   output logic [LARGURA-1:0] ula_a,
   output logic [LARGURA-1:0] ula_b,
   output logic [2:0]         ula_op,
   output logic               carregar,
   output logic [LARGURA-1:0] resultado_entrada,
   output logic               ocupado,
   output logic               concluido,
   output logic               erro
);

   localparam logic [3:0] CARGA_CONTADOR = 4'(LATENCIA_ULA - 1);

   estado_t estado_q, estado_d;
   logic    aceita_op;
   logic    aceita_limpa;
   logic    contador_zero;
   logic    erro_capturado;

`ifdef CONTROLADOR_PROTEGE_ERRO_EN
   assign erro_capturado = erro_ula;
`else
   logic unused_erro_ula;
   assign unused_erro_ula = erro_ula;
   assign erro_capturado  = 1'b0;
`endif

   contador_latencia #(
      .LARGURA_CONT (4)
   ) u_contador (
      .clk         (clk),
      .rst         (rst),
      .carga       (aceita_op),
      .valor       (CARGA_CONTADOR),
      .decrementar (estado_q == EXECUTA),
      .zero        (contador_zero)
   );

   always_comb begin
      estado_d     = estado_q;
      aceita_op    = 1'b0;
      aceita_limpa = 1'b0;
      carregar     = 1'b0;
      concluido    = 1'b0;
      unique case (estado_q)
         OCIOSO: begin
            // Clear wins; a simultaneous iniciar is dropped, not queued.
            if (limpar_memoria) begin
               aceita_limpa = 1'b1;
               estado_d     = LIMPA;
            end else if (iniciar) begin
               aceita_op = 1'b1;
               estado_d  = EXECUTA;
            end
         end
         EXECUTA: begin
            if (contador_zero) estado_d = GRAVA;
         end
         GRAVA: begin
            carregar  = !erro;
            concluido = 1'b1;
            estado_d  = OCIOSO;
         end
         LIMPA: begin
            carregar  = 1'b1;
            concluido = 1'b1;
            estado_d  = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   assign ocupado = (estado_q != OCIOSO);

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q          <= OCIOSO;
         ula_a             <= '0;
         ula_b             <= '0;
         ula_op            <= '0;
         resultado_entrada <= '0;
         erro              <= 1'b0;
      end else begin
         estado_q <= estado_d;
         if (aceita_op) begin
            ula_a  <= usar_memoria ? valor_memoria : operando_a;
            ula_b  <= operando_b;
            ula_op <= opcode;
            erro   <= 1'b0;
         end
         // Zero is staged at acceptance so it is on the bus during LIMPA.
         if (aceita_limpa) begin
            resultado_entrada <= '0;
            erro              <= 1'b0;
         end
         if ((estado_q == EXECUTA) && contador_zero) begin
            resultado_entrada <= resultado_ula;
            erro              <= erro_capturado;
         end
      end
   end

endmodule

// File: tb/tb_controlador_memoria_ula.sv
// Directed bench for controlador_memoria_ula: one instance with LATENCIA_ULA=1
// for the datapath tests and one with LATENCIA_ULA=3 for busy/reset tests.
module tb_controlador_memoria_ula;
   import ula_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       iniciar1, iniciar3, limpar, usar;
   logic [7:0] op_a, op_b;
   logic [2:0] opc;

   logic [7:0] mem1, mem3, res_ula1, res_ula3;
   logic       erro_ula1, erro_ula3;
   logic [7:0] ula_a1, ula_b1, res1, ula_a3, ula_b3, res3;
   logic [2:0] ula_op1, ula_op3;
   logic       carregar1, ocupado1, concluido1, erro1;
   logic       carregar3, ocupado3, concluido3, erro3;

   int checks = 0;
   int errors = 0;
   int n_concl, n_carr;

   always #5 clk = ~clk;

   function automatic logic [8:0] ula_modelo(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
      logic [7:0]  r;
      logic [15:0] p;
      logic        e;
      e = 1'b0;
      p = 16'(a) * 16'(b);
      case (op)
         OP_SOMA:      r = a + b;
         OP_SUBTRACAO: r = a - b;
         OP_AND:       r = a & b;
         OP_OR:        r = a | b;
         OP_XOR:       r = a ^ b;
         OP_MULT:      r = p[7:0];
         OP_DIV: begin
            if (b == 8'h00) begin
               r = 8'h00;
               e = 1'b1;
            end else begin
               r = a / b;
            end
         end
         default:      r = a;
      endcase
      return {e, r};
   endfunction

   assign {erro_ula1, res_ula1} = ula_modelo(ula_a1, ula_b1, ula_op1);
   assign {erro_ula3, res_ula3} = ula_modelo(ula_a3, ula_b3, ula_op3);

   // Memory registers
   always @(posedge clk) begin
      if (rst) begin
         mem1 <= 8'h00;
         mem3 <= 8'h00;
      end else begin
         if (carregar1) mem1 <= res1;
         if (carregar3) mem3 <= res3;
      end
   end

   controlador_memoria_ula #(.LARGURA(8), .LATENCIA_ULA(1)) dut1 (
      .clk(clk), .rst(rst), .iniciar(iniciar1), .limpar_memoria(limpar),
      .usar_memoria(usar), .operando_a(op_a), .operando_b(op_b), .opcode(opc),
      .valor_memoria(mem1), .resultado_ula(res_ula1), .erro_ula(erro_ula1),
      .ula_a(ula_a1), .ula_b(ula_b1), .ula_op(ula_op1), .carregar(carregar1),
      .resultado_entrada(res1), .ocupado(ocupado1), .concluido(concluido1), .erro(erro1)
   );

   controlador_memoria_ula #(.LARGURA(8), .LATENCIA_ULA(3)) dut3 (
      .clk(clk), .rst(rst), .iniciar(iniciar3), .limpar_memoria(limpar),
      .usar_memoria(usar), .operando_a(op_a), .operando_b(op_b), .opcode(opc),
      .valor_memoria(mem3), .resultado_ula(res_ula3), .erro_ula(erro_ula3),
      .ula_a(ula_a3), .ula_b(ula_b3), .ula_op(ula_op3), .carregar(carregar3),
      .resultado_entrada(res3), .ocupado(ocupado3), .concluido(concluido3), .erro(erro3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      assert (obs === esp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, esp);
      end
   endtask

   initial begin
      rst = 1'b1; iniciar1 = 1'b0; iniciar3 = 1'b0; limpar = 1'b0; usar = 1'b0;
      op_a = 8'h00; op_b = 8'h00; opc = 3'b000;
      tick(); tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("reset_dut1", {ula_a1, ula_b1, ula_op1, carregar1, res1, ocupado1, concluido1, erro1}, 0);
      chk("reset_dut3", {ula_a3, ula_b3, ula_op3, carregar3, res3, ocupado3, concluido3, erro3}, 0);

      // Soma 12 + 05
      op_a = 8'h12; op_b = 8'h05; opc = OP_SOMA; iniciar1 = 1'b1;
      tick(); iniciar1 = 1'b0;
      chk("soma_c1_operandos", {ula_a1, ula_b1, ula_op1}, {8'h12, 8'h05, 3'b000});
      chk("soma_c1_ctl", {ocupado1, carregar1, concluido1}, 3'b100);
      tick();
      chk("soma_c2_ctl", {ocupado1, carregar1, concluido1, erro1}, 4'b1110);
      chk("soma_c2_res", res1, 8'h17);
      tick();
      chk("soma_c3_mem", mem1, 8'h17);
      chk("soma_c3_ctl", {ocupado1, carregar1, concluido1}, 3'b000);

      // Subtracao using memory as operand A: 17 - 07
      usar = 1'b1; op_a = 8'hFF; op_b = 8'h07; opc = OP_SUBTRACAO; iniciar1 = 1'b1;
      tick(); iniciar1 = 1'b0; usar = 1'b0;
      chk("sub_mem_ula_a", {ula_a1, ula_op1}, {8'h17, 3'b001});
      tick();
      chk("sub_mem_c2", {carregar1, res1}, {1'b1, 8'h10});
      tick();
      chk("sub_mem_mem", mem1, 8'h10);

      // Divide by zero
      op_a = 8'h10; op_b = 8'h00; opc = OP_DIV; iniciar1 = 1'b1;
      tick(); iniciar1 = 1'b0;
      chk("div0_c1_erro", erro1, 1'b0);
      tick();
`ifdef CONTROLADOR_PROTEGE_ERRO_EN
      chk("div0_c2", {concluido1, carregar1, erro1}, 3'b101);
      tick();
      chk("div0_c3_mem", {mem1, erro1}, {8'h10, 1'b1});
`else
      chk("div0_c2", {concluido1, carregar1, erro1}, 3'b110);
      tick();
      chk("div0_c3_mem", {mem1, erro1}, {8'h00, 1'b0});
`endif

      // passa_a 17 to set memory, then clear with a simultaneous iniciar
      op_a = 8'h17; op_b = 8'h00; opc = OP_PASSA_A; iniciar1 = 1'b1;
      tick(); iniciar1 = 1'b0;
      chk("passa_c1_erro", erro1, 1'b0);
      tick(); tick();
      chk("passa_mem", mem1, 8'h17);
      op_a = 8'hAA; op_b = 8'hBB; opc = OP_AND; iniciar1 = 1'b1; limpar = 1'b1;
      tick(); iniciar1 = 1'b0; limpar = 1'b0;
      chk("limpa_c1_ctl", {carregar1, concluido1, ocupado1}, 3'b111);
      chk("limpa_c1_res", res1, 8'h00);
      chk("limpa_operandos", {ula_a1, ula_b1, ula_op1}, {8'h17, 8'h00, 3'b111});
      tick();
      chk("limpa_c2_mem", {mem1, ocupado1, carregar1}, {8'h00, 1'b0, 1'b0});
      tick();
      chk("limpa_nao_enfileira", ocupado1, 1'b0);

      // LATENCIA_ULA=3: extra iniciar pulses while busy are ignored
      tick();
      op_a = 8'h03; op_b = 8'h04; opc = OP_SOMA; iniciar3 = 1'b1; n_concl = 0;
      tick(); n_concl += int'(concluido3);
      chk("lat3_c1_ocupado", ocupado3, 1'b1);
      op_a = 8'h55;
      tick(); n_concl += int'(concluido3);
      iniciar3 = 1'b0;
      tick(); n_concl += int'(concluido3);
      chk("lat3_c3_sem_conclusao", {concluido3, carregar3}, 2'b00);
      tick(); n_concl += int'(concluido3);
      chk("lat3_c4_ctl", {carregar3, concluido3}, 2'b11);
      chk("lat3_c4_res", res3, 8'h07);
      tick(); n_concl += int'(concluido3);
      chk("lat3_c5_livre", {ocupado3, mem3}, {1'b0, 8'h07});
      for (int i = 0; i < 3; i++) begin
         tick(); n_concl += int'(concluido3);
      end
      chk("lat3_um_pulso", n_concl, 1);

      // Reset during EXECUTA aborts with no load pulse
      op_a = 8'h09; op_b = 8'h01; opc = OP_SOMA; iniciar3 = 1'b1; n_carr = 0;
      tick(); iniciar3 = 1'b0; n_carr += int'(carregar3);
      tick(); n_carr += int'(carregar3);
      chk("rst_c2_ocupado", ocupado3, 1'b1);
      rst = 1'b1;
      tick(); rst = 1'b0; n_carr += int'(carregar3);
      chk("rst_c3_ocioso", {ocupado3, carregar3, concluido3}, 3'b000);
      for (int i = 0; i < 4; i++) begin
         tick(); n_carr += int'(carregar3);
      end
      chk("rst_sem_carregar", n_carr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
